eff_env_follower: RTL
=====================

Name: eff_env_follower

Overview:
Envelope follower for the effect chain. Tremolo blocks impose an amplitude envelope on the signal; this block recovers one from incoming audio.
- Takes signed samples and computes a saturated magnitude.
- Tracks that magnitude with shift-based attack/release smoothing plus a peak-hold timer.
- Outputs the envelope alongside a latency-matched pass-through of the audio, so it can sit inline and drive downstream gain, gate or auto-wah stages.

Parameters:
DATA_WIDTH, 8, sample width (signed two's complement)
FRAC_BITS, 4, fractional bits in the envelope accumulator
ATK_SHIFT, 1, attack coefficient, step = diff >> ATK_SHIFT
REL_SHIFT, 4, release coefficient, step = diff >> REL_SHIFT
HOLD_SAMPLES, 4, valid samples the peak is held before release; 0 = no hold

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  follower enable
data_i  input  DATA_WIDTH  signed input sample
vld_i  input  1  sample strobe
data_o  output  DATA_WIDTH  data_i delayed 3 cycles, unmodified
env_o  output  DATA_WIDTH-1  unsigned envelope, acc >> FRAC_BITS
vld_o  output  1  vld_i delayed 3 cycles

Behaviour:
- Reset: data_o=0, env_o=0, vld_o=0, acc=0, hold_cnt=0, state=RELEASE. Reset mid-operation clears everything the next cycle; the in-flight vld pipe is dropped.
- Pipeline, fixed 3-cycle latency for a vld_i at edge t:
  - t+1: mag = |data_i|. The most negative value saturates to 2^(DATA_WIDTH-1)-1 (-128 -> 127).
  - t+2: acc/state update.
  - t+3: data_o, env_o and vld_o registered. env_o includes that sample's update.
- vld pipe shifts every cycle regardless of en. Non-valid cycles never change acc, hold_cnt or state.
- acc width is DATA_WIDTH-1+FRAC_BITS, unsigned. Define m = mag << FRAC_BITS.
- Per valid sample, with en=1, evaluate in priority order:
  1. m > acc: state=ATTACK; acc += max(1, (m-acc) >> ATK_SHIFT); hold_cnt = HOLD_SAMPLES.
  2. Else, state in {ATTACK, HOLD} and hold_cnt != 0: state=HOLD; hold_cnt -= 1; acc unchanged.
  3. Else: state=RELEASE. If acc > m, acc -= max(1, (acc-m) >> REL_SHIFT); if acc == m, acc is unchanged.
- The max(1, ...) term guarantees exact convergence to m. acc can never overshoot m or wrap.
- HOLD_SAMPLES=0: ATTACK goes directly to RELEASE evaluation on the next non-rising sample.
- en=0, any cycle: acc=0, hold_cnt=0, state=RELEASE the next cycle. env_o shows 0 from the following output register onward. data_o/vld_o pass-through continues unaffected.
- en rising: tracking restarts from acc=0.

Decomposition:
- Package eff_pkg: env_state_t enum {RELEASE, ATTACK, HOLD}, and a function sat_abs(data) returning DATA_WIDTH-1 bits.
- Sub-module eff_env_step (combinational): inputs acc, m, shift; outputs the signed-direction step with the max(1, ...) rule. One instance serves attack, one serves release.
- FSM, hold counter and pipeline registers stay in eff_env_follower.

Test Plan:
1. Reset with defaults -> data_o=0, env_o=0, vld_o=0. Pulse vld_i during reset -> vld_o stays 0.
2. From acc=0, en=1, data_i=100 valid every cycle:
   - env_o sequence is 50, 75, 87, 93, 96, 98, 99, 99, 99, 99, 99, 100.
   - env_o reaches exactly 100 on sample 12.
   - vld_o lags vld_i by exactly 3 cycles; data_o equals data_i delayed 3.
3. Repeat scenario 2 with data_i=-100 -> identical env_o sequence. data_i=-128 held -> env_o converges to 127, never wraps.
4. After scenario 2, switch to data_i=0:
   - 4 samples hold env_o=100.
   - Then release: 93, 87 (acc 1500, 1407).
   - Continues decaying monotonically to 0 exactly.
5. Insert 5-cycle vld_i gaps between samples in scenario 2 -> same env_o value sequence, and env_o only changes on the cycle vld_o is asserted.
6. Drop en for one cycle mid-attack -> env_o=0 on the next output. data_o/vld_o continue uninterrupted. Resume with data_i=100 -> sequence restarts at 50. Assert rst mid-hold -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/eff_pkg.sv
// Shared types and helpers for the effect-chain envelope follower.
// sat_abs works on a wide sign-extended sample so one function serves any width.
package eff_pkg;

    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2
    } env_state_t;

    localparam int SAT_W = 32;

    // Magnitude of a width-bit sample; the most negative code clips to the positive full scale.
    function automatic logic [SAT_W-2:0] sat_abs(input logic signed [SAT_W-1:0] data,
                                                 input int width);
        logic [SAT_W-1:0] lim;
        logic [SAT_W-1:0] mag;
        lim = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        mag = data[SAT_W-1] ? -data : data;
        if (mag > lim) mag = lim;
        return mag[SAT_W-2:0];
    endfunction

endpackage

// File: rtl/eff_env_step.sv
// Signed smoothing step toward target m: +/- max(1, |m-acc| >> shift), zero when equal.
// The step never exceeds the distance, so the accumulator cannot overshoot.
module eff_env_step #(
    parameter int ACC_W = 11
) (
    input  logic [ACC_W-1:0]        acc,
    input  logic [ACC_W-1:0]        m,
    input  logic [4:0]              shift,
    output logic signed [ACC_W:0]   step
);

    logic [ACC_W-1:0] diff;
    logic [ACC_W-1:0] mag;

    always_comb begin
        diff = (m > acc) ? (m - acc) : (acc - m);
        mag  = diff >> shift;
        if (mag == '0) mag = ACC_W'(1);
        step = '0;
        if (m > acc) begin
            step = $signed({1'b0, mag});
        end else if (acc > m) begin
            step = -$signed({1'b0, mag});
        end
    end

endmodule

// File: rtl/eff_env_follower.sv
// Inline envelope follower: saturated magnitude, attack/hold/release smoothing,
// with the audio delayed to line up with the envelope (3-cycle latency).
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  RELEASE | acc decays toward the current magnitude (or sits on it)
//  ATTACK  | last valid sample pushed acc upward; hold timer reloaded
//  HOLD    | peak held, counting down valid samples before release
module eff_env_follower
    import eff_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAC_BITS    = 4,
    parameter int ATK_SHIFT    = 1,
    parameter int REL_SHIFT    = 4,
    parameter int HOLD_SAMPLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    vld_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH-2:0]   env_o,
    output logic                    vld_o
);

    localparam int MAG_W  = DATA_WIDTH - 1;
    localparam int ACC_W  = MAG_W + FRAC_BITS;
    localparam int HOLD_W = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);

    logic [MAG_W-1:0]       mag_c;
    logic [MAG_W-1:0]       mag1;
    logic                   vld1;
    logic                   vld2;
    logic [DATA_WIDTH-1:0]  data1;
    logic [DATA_WIDTH-1:0]  data2;

    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       m;
    logic [HOLD_W-1:0]      hold_cnt;
    env_state_t             state;
    logic signed [ACC_W:0]  atk_step;
    logic signed [ACC_W:0]  rel_step;

    assign mag_c = MAG_W'(sat_abs(SAT_W'($signed(data_i)), DATA_WIDTH));
    assign m     = {mag1, {FRAC_BITS{1'b0}}};

    eff_env_step #(.ACC_W(ACC_W)) u_atk_step (
        .acc   (acc),
        .m     (m),
        .shift (5'(ATK_SHIFT)),
        .step  (atk_step)
    );

    eff_env_step #(.ACC_W(ACC_W)) u_rel_step (
        .acc   (acc),
        .m     (m),
        .shift (5'(REL_SHIFT)),
        .step  (rel_step)
    );

    // Sample/valid pipeline runs regardless of en so the pass-through never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag1   <= '0;
            vld1   <= 1'b0;
            data1  <= '0;
            vld2   <= 1'b0;
            data2  <= '0;
            vld_o  <= 1'b0;
            data_o <= '0;
            env_o  <= '0;
        end else begin
            mag1   <= mag_c;
            vld1   <= vld_i;
            data1  <= data_i;
            vld2   <= vld1;
            data2  <= data1;
            vld_o  <= vld2;
            data_o <= data2;
            env_o  <= acc[ACC_W-1:FRAC_BITS];
        end
    end

    // Step sums wrap modulo 2^ACC_W; a negative release step therefore subtracts.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            acc      <= '0;
            hold_cnt <= '0;
            state    <= RELEASE;
        end else if (vld1) begin
            if (m > acc) begin
                state    <= ATTACK;
                acc      <= ACC_W'({1'b0, acc} + $unsigned(atk_step));
                hold_cnt <= HOLD_W'(HOLD_SAMPLES);
            end else if ((state == ATTACK || state == HOLD) && hold_cnt != '0) begin
                state    <= HOLD;
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end else begin
                state    <= RELEASE;
                acc      <= ACC_W'({1'b0, acc} + $unsigned(rel_step));
            end
        end
    end

endmodule
